sr595_driver: RTL and testbench
===============================

SR595_DRIVER -- requirements
Module: sr595_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per transfer (multiple of 8; 8 per chained 74HC595).
REQ-002 SHALL have parameter CLK_DIV, default 4, system clocks per half shift-clock period (legal range 1..255).
REQ-003 SHALL have parameter LSB_FIRST, default 0: 0 shifts i_Data MSB first, 1 shifts LSB first.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port i_Clock  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port i_Reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port i_Data  input  DATA_WIDTH  parallel word to present on the 595 outputs.
REQ-008 SHALL have port i_Valid  input  1  i_Data valid; transfer accepted when i_Valid & o_Ready.
REQ-009 SHALL have port o_Ready  output  1  driver idle and able to accept a word.
REQ-010 SHALL have port o_Done  output  1  one-cycle pulse when the latch pulse has completed.
REQ-011 SHALL have port o_SerialData  output  1  to 595 SER.
REQ-012 SHALL have port o_ShiftClock  output  1  to 595 SRCLK (595 samples SER on rising edge).
REQ-013 SHALL have port o_LatchClock  output  1  to 595 RCLK (595 updates outputs on rising edge).

Function
REQ-014 All outputs SHALL be driven directly from flip-flops (no combinational paths from inputs to outputs).
REQ-015 States SHALL be IDLE, SETUP, SHIFT_HIGH and LATCH.
REQ-016 IDLE: o_Ready=1, o_ShiftClock=0, o_LatchClock=0; on handshake, capture i_Data, load bit counter DATA_WIDTH-1, go to SETUP.
REQ-017 SETUP: o_ShiftClock=0, o_SerialData = current bit (MSB or LSB per LSB_FIRST), held CLK_DIV cycles, then go to SHIFT_HIGH.
REQ-018 SHIFT_HIGH: o_ShiftClock=1 for CLK_DIV cycles, o_SerialData unchanged; then, if counter=0, go to LATCH; else shift word, decrement counter, go to SETUP.
REQ-019 LATCH: o_ShiftClock=0, o_LatchClock=1 for CLK_DIV cycles; then go to IDLE with o_Done=1 for exactly the first IDLE cycle.
REQ-020 o_SerialData SHALL change only on entry to SETUP (setup time CLK_DIV cycles, hold time CLK_DIV cycles).
REQ-021 Timing: handshake in cycle 0 -> o_Done=1 and o_Ready=1 in cycle 1+CLK_DIV*(2*DATA_WIDTH+1).
REQ-022 A handshake in the o_Done cycle SHALL be accepted, giving back-to-back transfers with no idle gap.
REQ-023 o_Ready=0 outside IDLE; i_Valid and i_Data SHALL be ignored while o_Ready=0.
REQ-024 Exactly DATA_WIDTH o_ShiftClock rising edges and one o_LatchClock rising edge SHALL occur per transfer.
REQ-025 The divide counter SHALL be width $clog2(CLK_DIV+1) and SHALL reload to CLK_DIV-1 on every state entry.

Reset
REQ-026 While i_Reset=1 at a clock edge: state->IDLE, o_Ready=0, o_Done=0, o_SerialData=0, o_ShiftClock=0, o_LatchClock=0, counters and word cleared.
REQ-027 o_Ready SHALL rise the first cycle after i_Reset deasserts.
REQ-028 Reset mid-transfer SHALL abort the transfer, produce no further shift or latch edges and no o_Done.

Structure
REQ-029 Package sr595_pkg SHALL hold the state enum typedef (sr595_state_t).
REQ-030 Sub-module sr595_tick_gen SHALL implement the CLK_DIV down-counter (inputs: clock, reset, reload; output: one-cycle terminal tick).
REQ-031 An elaboration-time check SHALL reject CLK_DIV=0 and DATA_WIDTH not a multiple of 8.

Verification
REQ-032 Bench SHALL use a behavioural 74HC595 model (8-bit, chainable) on the outputs.
REQ-033 DATA_WIDTH=8, CLK_DIV=2, i_Data=8'hA5 -> model outputs 8'hA5, o_Done in cycle 35, 8 SRCLK and 1 RCLK edges.
REQ-034 LSB_FIRST=1, i_Data=8'h01 -> first SER bit 1, model outputs 8'h80.
REQ-035 DATA_WIDTH=16, two chained models, i_Data=16'h1234 -> downstream model 8'h12, upstream model 8'h34.
REQ-036 Back-to-back: 8'hFF, then 8'h00 offered in the o_Done cycle -> second accepted that cycle, outputs 8'hFF then 8'h00.
REQ-037 Reset asserted after bit 3 of 8'h3C -> no RCLK edge, model outputs keep prior value, o_Ready=1 the cycle after release.

Source files
------------

// File: rtl/sr595_pkg.sv
// rtl/sr595_pkg.sv - shared types for the 74HC595 serial driver
package sr595_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SETUP      = 2'd1,
    ST_SHIFT_HIGH = 2'd2,
    ST_LATCH      = 2'd3
  } sr595_state_t;

endpackage

// File: rtl/sr595_tick_gen.sv
// rtl/sr595_tick_gen.sv - CLK_DIV down-counter producing a terminal tick
module sr595_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Reload,
  output logic o_Tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter parks at zero, so the tick stays high until the next reload.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Reload) begin
      cnt_d = RELOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_Tick = (cnt_q == '0);

endmodule

// File: rtl/sr595_driver.sv
// rtl/sr595_driver.sv - shifts a parallel word into chained 74HC595s and latches it
module sr595_driver
  import sr595_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int LSB_FIRST  = 0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  output logic                  o_Done,
  output logic                  o_SerialData,
  output logic                  o_ShiftClock,
  output logic                  o_LatchClock
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("sr595_driver: CLK_DIV must be in 1..255");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("sr595_driver: DATA_WIDTH must be a non-zero multiple of 8");
  end

  sr595_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  ser_q, ser_d;
  logic                  sclk_q, sclk_d;
  logic                  lclk_q, lclk_d;
  logic                  tick;
  logic                  accept;

  assign accept = i_Valid & ready_q;

  sr595_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Reload (state_d != state_q),
    .o_Tick   (tick)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      bit_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      ser_q   <= 1'b0;
      sclk_q  <= 1'b0;
      lclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ser_q   <= ser_d;
      sclk_q  <= sclk_d;
      lclk_q  <= lclk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          word_d  = i_Data;
          bit_d   = BIT_W'(DATA_WIDTH - 1);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT_HIGH;
      end
      ST_SHIFT_HIGH: begin
        if (tick) begin
          if (bit_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            word_d  = (LSB_FIRST != 0) ? (word_q >> 1) : (word_q << 1);
            bit_d   = bit_q - BIT_W'(1);
            state_d = ST_SETUP;
          end
        end
      end
      ST_LATCH: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so every pin comes straight off a flop.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_q == ST_LATCH) && (state_d == ST_IDLE);
    sclk_d  = (state_d == ST_SHIFT_HIGH);
    lclk_d  = (state_d == ST_LATCH);
    ser_d   = ser_q;
    if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
      ser_d = (LSB_FIRST != 0) ? word_d[0] : word_d[DATA_WIDTH-1];
    end
  end

  assign o_Ready      = ready_q;
  assign o_Done       = done_q;
  assign o_SerialData = ser_q;
  assign o_ShiftClock = sclk_q;
  assign o_LatchClock = lclk_q;

endmodule

// File: tb/tb_sr595_driver.sv
// tb/tb_sr595_driver.sv - three driver configurations against behavioural 74HC595 models
module tb_sr595_driver;

  localparam int CD0 = 2, CD1 = 3, CD2 = 1;
  localparam int DW0 = 8, DW1 = 8, DW2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst = 3'b111;
  logic [2:0]  vld = 3'b000;
  logic [7:0]  din0 = '0;
  logic [7:0]  din1 = '0;
  logic [15:0] din2 = '0;
  wire  [2:0]  rdy, dn, ser, sck, lck;

  sr595_driver #(.DATA_WIDTH(DW0), .CLK_DIV(CD0), .LSB_FIRST(0)) dut_msb (
    .i_Clock(clk), .i_Reset(rst[0]), .i_Data(din0), .i_Valid(vld[0]),
    .o_Ready(rdy[0]), .o_Done(dn[0]), .o_SerialData(ser[0]),
    .o_ShiftClock(sck[0]), .o_LatchClock(lck[0]));

  sr595_driver #(.DATA_WIDTH(DW1), .CLK_DIV(CD1), .LSB_FIRST(1)) dut_lsb (
    .i_Clock(clk), .i_Reset(rst[1]), .i_Data(din1), .i_Valid(vld[1]),
    .o_Ready(rdy[1]), .o_Done(dn[1]), .o_SerialData(ser[1]),
    .o_ShiftClock(sck[1]), .o_LatchClock(lck[1]));

  sr595_driver #(.DATA_WIDTH(DW2), .CLK_DIV(CD2), .LSB_FIRST(0)) dut_chain (
    .i_Clock(clk), .i_Reset(rst[2]), .i_Data(din2), .i_Valid(vld[2]),
    .o_Ready(rdy[2]), .o_Done(dn[2]), .o_SerialData(ser[2]),
    .o_ShiftClock(sck[2]), .o_LatchClock(lck[2]));

  // 74HC595 models: SER sampled on SRCLK rise, storage register loaded on RCLK rise
  logic [7:0] sr0 = '0, q0 = '0, sr1 = '0, q1 = '0;
  logic [7:0] sr2u = '0, sr2d = '0, q2u = '0, q2d = '0;
  int sc0 = 0, sc1 = 0, sc2 = 0, rc0 = 0, rc1 = 0, rc2 = 0, dc0 = 0;
  bit hist1 [256];

  always @(posedge sck[0]) begin sr0 <= {sr0[6:0], ser[0]}; sc0 <= sc0 + 1; end
  always @(posedge lck[0]) begin q0 <= sr0; rc0 <= rc0 + 1; end
  always @(posedge sck[1]) begin sr1 <= {sr1[6:0], ser[1]}; hist1[sc1 % 256] <= ser[1]; sc1 <= sc1 + 1; end
  always @(posedge lck[1]) begin q1 <= sr1; rc1 <= rc1 + 1; end
  always @(posedge sck[2]) begin sr2u <= {sr2u[6:0], ser[2]}; sr2d <= {sr2d[6:0], sr2u[7]}; sc2 <= sc2 + 1; end
  always @(posedge lck[2]) begin q2u <= sr2u; q2d <= sr2d; rc2 <= rc2 + 1; end
  always @(posedge clk) if (dn[0]) dc0 <= dc0 + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int get_sc(input int k);
    return (k == 0) ? sc0 : (k == 1) ? sc1 : sc2;
  endfunction

  function automatic int get_rc(input int k);
    return (k == 0) ? rc0 : (k == 1) ? rc1 : rc2;
  endfunction

  function automatic logic [15:0] get_q(input int k);
    return (k == 0) ? {8'h00, q0} : (k == 1) ? {8'h00, q1} : {q2d, q2u};
  endfunction

  function automatic int get_dw(input int k);
    return (k == 2) ? DW2 : (k == 1) ? DW1 : DW0;
  endfunction

  function automatic int lat_exp(input int k);
    int cd;
    cd = (k == 0) ? CD0 : (k == 1) ? CD1 : CD2;
    return 1 + cd * (2 * get_dw(k) + 1);
  endfunction

  // MSB first leaves the word as-is on the pins; LSB first lands bit 0 on QH (output bit 7).
  function automatic logic [15:0] exp_q(input int k, input logic [15:0] d);
    logic [15:0] r;
    r = '0;
    if (k == 0) r = {8'h00, d[7:0]};
    else if (k == 1) for (int i = 0; i < 8; i++) r[7-i] = d[i];
    else r = d;
    return r;
  endfunction

  task automatic set_in(input int k, input logic v, input logic [15:0] d);
    vld[k] = v;
    case (k)
      0: din0 = d[7:0];
      1: din1 = d[7:0];
      default: din2 = d;
    endcase
  endtask

  // Called at a negedge; returns at the negedge of the o_Done cycle with i_Valid low.
  task automatic send(input int k, input logic [15:0] d, output int waited, output int lat);
    waited = 0;
    while (!rdy[k] && waited < 500) begin @(negedge clk); waited++; end
    set_in(k, 1'b1, d);
    @(negedge clk);
    lat = 1;
    while (!dn[k] && lat < 2000) begin
      set_in(k, 1'($urandom), 16'($urandom));
      @(negedge clk);
      lat++;
    end
    set_in(k, 1'b0, 16'($urandom));
    if (!dn[k]) lat = -1;
  endtask

  task automatic xfer_check(input int k, input logic [15:0] d, input int scb, input int rcb, input int lat);
    chk($sformatf("latency_k%0d", k), lat, lat_exp(k));
    chk($sformatf("ready_at_done_k%0d", k), {31'd0, rdy[k]}, 1);
    chk($sformatf("model_out_k%0d", k), {16'd0, get_q(k)}, {16'd0, exp_q(k, d)});
    chk($sformatf("srclk_edges_k%0d", k), get_sc(k) - scb, get_dw(k));
    chk($sformatf("rclk_edges_k%0d", k), get_rc(k) - rcb, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    int w, l, scb, rcb, dcb, tries;
    logic [15:0] d, prior;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready_k%0d", k), {31'd0, rdy[k]}, 0);
      chk($sformatf("rst_out_k%0d", k), {28'd0, dn[k], ser[k], sck[k], lck[k]}, 0);
    end
    rst = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("ready_after_rst_k%0d", k), {31'd0, rdy[k]}, 1);

    scb = sc0; rcb = rc0;
    send(0, 16'h00A5, w, l);
    xfer_check(0, 16'h00A5, scb, rcb, l);

    scb = sc1; rcb = rc1;
    send(1, 16'h0001, w, l);
    xfer_check(1, 16'h0001, scb, rcb, l);
    chk("lsb_first_bit", {31'd0, hist1[scb % 256]}, 1);

    scb = sc2; rcb = rc2;
    send(2, 16'h1234, w, l);
    xfer_check(2, 16'h1234, scb, rcb, l);
    chk("chain_downstream", {24'd0, q2d}, 32'h12);
    chk("chain_upstream", {24'd0, q2u}, 32'h34);

    scb = sc0; rcb = rc0;
    send(0, 16'h00FF, w, l);
    xfer_check(0, 16'h00FF, scb, rcb, l);
    scb = sc0; rcb = rc0;
    send(0, 16'h0000, w, l);
    chk("b2b_accept_in_done_cycle", w, 0);
    xfer_check(0, 16'h0000, scb, rcb, l);

    for (int k = 0; k < 3; k++) begin
      repeat (5) begin
        d = 16'($urandom);
        scb = get_sc(k); rcb = get_rc(k);
        send(k, d, w, l);
        xfer_check(k, d, scb, rcb, l);
      end
    end

    // Abort a transfer of 8'h3C after its third shift edge
    prior = get_q(0);
    scb = sc0; rcb = rc0; dcb = dc0;
    set_in(0, 1'b1, 16'h003C);
    @(negedge clk);
    set_in(0, 1'b0, 16'h0000);
    tries = 0;
    while (sc0 < scb + 3 && tries < 500) begin @(negedge clk); tries++; end
    chk("abort_reached_bit3", {31'd0, sc0 >= scb + 3}, 1);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready", {31'd0, rdy[0]}, 0);
    chk("abort_rst_outs", {28'd0, dn[0], ser[0], sck[0], lck[0]}, 0);
    @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("abort_ready_after_release", {31'd0, rdy[0]}, 1);
    repeat (60) @(negedge clk);
    chk("abort_no_more_srclk", sc0 - scb, 3);
    chk("abort_no_rclk", rc0 - rcb, 0);
    chk("abort_no_done", dc0 - dcb, 0);
    chk("abort_outputs_kept", {16'd0, get_q(0)}, {16'd0, prior});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
